mm_timer_multi: RTL and testbench

Memory-mapped multi-channel timer: a parametrised successor to the single-compare system timer. It has one shared free-running counter of configurable width, a programmable prescaler and NUM_CH compare channels. Each channel supports one-shot or periodic (auto-reload) mode and has its own sticky, maskable interrupt. It sits on the SoC Avalon-MM peripheral bus next to the core and drives the core's timer interrupt inputs.

---
 rtl/mm_timer_multi.sv | 134 +++++++++++++
 tb/tb_mm_timer_multi.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_timer_multi.sv
// Memory-mapped multi-channel timer: shared prescaled free-running counter with
// NUM_CH compare channels, each one-shot or auto-reload, with sticky maskable interrupts.
module mm_timer_multi #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 64,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        addr,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] timer_irq,
    output logic              timer_irq_any
);

    localparam int HI_W = CNT_W - 32;

    logic               en;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;
    logic [CNT_W-1:0]   count;
    logic [31:0]        shadow;
    logic [CNT_W-1:0]   cmp [NUM_CH];
    logic [31:0]        period [NUM_CH];
    logic [NUM_CH-1:0]  periodic;
    logic [NUM_CH-1:0]  pend;
    logic [NUM_CH-1:0]  irq_en;

    logic               tick;
    logic               cnt_wr;
    logic               wr_ctrl;
    logic               wr_presc;
    logic               wr_pend;
    logic               wr_irq_en;
    logic [CNT_W-1:0]   count_inc;
    logic [63:0]        count_ext;
    logic [63:0]        cmp_ext [NUM_CH];
    logic [NUM_CH-1:0]  evt;
    logic [31:0]        rdata;

    function automatic logic [5:0] ch_addr(input int n, input int k);
        return 6'(8 + 4 * n + k);
    endfunction

    assign wr_ctrl   = write && (addr == 6'd0);
    assign wr_presc  = write && (addr == 6'd1);
    assign wr_pend   = write && (addr == 6'd4);
    assign wr_irq_en = write && (addr == 6'd5);
    assign cnt_wr    = write && ((addr == 6'd2) || (addr == 6'd3));
    assign tick      = en && (pcnt == presc);
    assign count_inc = count + CNT_W'(1);
    assign count_ext = 64'(count);

    // A bus write to the counter replaces the increment, so no compare event that cycle.
    always_comb begin
        evt = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            cmp_ext[n] = 64'(cmp[n]);
            evt[n]     = tick && !cnt_wr && (count_inc == cmp[n]);
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            6'd0:    rdata[0] = en;
            6'd1:    rdata = 32'(presc);
            6'd2:    rdata = count_ext[31:0];
            6'd3:    rdata = shadow;
            6'd4:    rdata = 32'(pend);
            6'd5:    rdata = 32'(irq_en);
            default: rdata = '0;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
            if (addr == ch_addr(n, 0)) rdata = cmp_ext[n][31:0];
            if (addr == ch_addr(n, 1)) rdata = cmp_ext[n][63:32];
            if (addr == ch_addr(n, 2)) rdata = period[n];
            if (addr == ch_addr(n, 3)) rdata = {31'b0, periodic[n]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            presc    <= '0;
            pcnt     <= '0;
            count    <= '0;
            shadow   <= '0;
            readdata <= '0;
            pend     <= '0;
            irq_en   <= '0;
            periodic <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cmp[n]    <= '1;
                period[n] <= '0;
            end
        end else begin
            if (read) begin
                readdata <= rdata;
                if (addr == 6'd2) shadow <= count_ext[63:32];
            end
            if (wr_ctrl)   en     <= writedata[0];
            if (wr_presc)  presc  <= writedata[PRESC_W-1:0];
            if (wr_irq_en) irq_en <= writedata[NUM_CH-1:0];

            if (wr_presc || (wr_ctrl && !writedata[0]) || !en || tick) pcnt <= '0;
            else pcnt <= pcnt + PRESC_W'(1);

            if (write && addr == 6'd2)      count[31:0]       <= writedata;
            else if (write && addr == 6'd3) count[CNT_W-1:32] <= writedata[HI_W-1:0];
            else if (tick)                  count             <= count_inc;

            for (int n = 0; n < NUM_CH; n++) begin
                if (evt[n])                         pend[n] <= 1'b1;
                else if (wr_pend && writedata[n])   pend[n] <= 1'b0;

                // A bus write to either compare half discards that cycle's reload.
                if (write && addr == ch_addr(n, 0))      cmp[n][31:0]       <= writedata;
                else if (write && addr == ch_addr(n, 1)) cmp[n][CNT_W-1:32] <= writedata[HI_W-1:0];
                else if (evt[n] && periodic[n])          cmp[n] <= cmp[n] + CNT_W'(period[n]);

                if (write && addr == ch_addr(n, 2)) period[n]   <= writedata;
                if (write && addr == ch_addr(n, 3)) periodic[n] <= writedata[0];
            end
        end
    end

    assign timer_irq     = pend & irq_en;
    assign timer_irq_any = |timer_irq;

endmodule

// File: tb/tb_mm_timer_multi.sv
// Bench for mm_timer_multi (40-bit counter, two channels): register table, directed
// corner sequences and a randomized phase checked against an arithmetic reference model.
module tb_mm_timer_multi;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 40;
    localparam int PRESC_W = 16;
    localparam longint unsigned MASK = (64'd1 << CNT_W) - 1;
    localparam longint unsigned LO32 = 64'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [5:0]        addr = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] timer_irq;
    logic              timer_irq_any;

    mm_timer_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst), .addr(addr), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata),
        .timer_irq(timer_irq), .timer_irq_any(timer_irq_any)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    // Reference model state: timer registers as plain integers.
    bit              m_en;
    longint unsigned m_presc, m_pcnt, m_cnt, m_shadow;
    longint unsigned m_cmp [NUM_CH];
    longint unsigned m_period [NUM_CH];
    bit              m_periodic [NUM_CH];
    bit              m_pend [NUM_CH];
    bit              m_irq_en [NUM_CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_presc = 0; m_pcnt = 0; m_cnt = 0; m_shadow = 0;
        for (int n = 0; n < NUM_CH; n++) begin
            m_cmp[n] = MASK; m_period[n] = 0; m_periodic[n] = 0; m_pend[n] = 0; m_irq_en[n] = 0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        logic [31:0] v;
        int ai;
        int n;
        v = '0;
        ai = int'(a);
        if (ai == 0) v[0] = m_en;
        else if (ai == 1) v = 32'(m_presc);
        else if (ai == 2) v = 32'(m_cnt & LO32);
        else if (ai == 3) v = 32'(m_shadow);
        else if (ai == 4) for (int k = 0; k < NUM_CH; k++) v[k] = m_pend[k];
        else if (ai == 5) for (int k = 0; k < NUM_CH; k++) v[k] = m_irq_en[k];
        else if (ai >= 8 && ai < 8 + 4 * NUM_CH) begin
            n = (ai - 8) / 4;
            case ((ai - 8) % 4)
                0: v = 32'(m_cmp[n] & LO32);
                1: v = 32'(m_cmp[n] >> 32);
                2: v = 32'(m_period[n]);
                default: v = 32'(m_periodic[n]);
            endcase
        end
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_irq();
        logic [NUM_CH-1:0] v;
        for (int n = 0; n < NUM_CH; n++) v[n] = m_pend[n] && m_irq_en[n];
        return v;
    endfunction

    task automatic model_step(input logic r, input logic w, input logic [5:0] a, input logic [31:0] d);
        bit tick, cw;
        bit ev [NUM_CH];
        longint unsigned nxt, dd;
        int base;
        dd   = longint'(64'(d));
        tick = m_en && (m_pcnt == m_presc);
        cw   = w && (a == 2 || a == 3);
        nxt  = (m_cnt + 1) & MASK;
        for (int n = 0; n < NUM_CH; n++) ev[n] = tick && !cw && (nxt == m_cmp[n]);
        if (r && a == 2) m_shadow = m_cnt >> 32;
        if ((w && a == 1) || (w && a == 0 && !d[0]) || !m_en || tick) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;
        if (w && a == 0) m_en = d[0];
        if (w && a == 1) m_presc = dd & 64'hFFFF;
        if (w && a == 2) m_cnt = (m_cnt & ~LO32) | dd;
        else if (w && a == 3) m_cnt = ((dd << 32) | (m_cnt & LO32)) & MASK;
        else if (tick) m_cnt = nxt;
        for (int n = 0; n < NUM_CH; n++) begin
            base = 8 + 4 * n;
            if (w && a == 5) m_irq_en[n] = d[n];
            if (ev[n]) m_pend[n] = 1;
            else if (w && a == 4 && d[n]) m_pend[n] = 0;
            if (w && a == base) m_cmp[n] = (m_cmp[n] & ~LO32) | dd;
            else if (w && a == base + 1) m_cmp[n] = ((dd << 32) | (m_cmp[n] & LO32)) & MASK;
            else if (ev[n] && m_periodic[n]) m_cmp[n] = (m_cmp[n] + m_period[n]) & MASK;
            if (w && a == base + 2) m_period[n] = dd;
            if (w && a == base + 3) m_periodic[n] = d[0];
        end
    endtask

    // One bus cycle: drive at negedge, model follows the edge, check at next negedge.
    task automatic cycle(input logic r, input logic w, input logic [5:0] a, input logic [31:0] d);
        addr = a; read = r; write = w; writedata = d;
        @(posedge clk);
        if (r) exp_q.push_back(model_read(a));
        model_step(r, w, a, d);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        check("irq", timer_irq, exp_irq());
        check("irq_any", timer_irq_any, |exp_irq());
        if (r) check($sformatf("rdata_a%0d", a), readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] v);
        cycle(1'b1, 1'b0, a, '0);
        v = readdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_irq(input int idx, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (timer_irq[idx]) break;
            idle(1);
        end
        check($sformatf("wait_irq%0d", idx), timer_irq[idx], 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; read = 1'b0; write = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("reset_irq", timer_irq, 0);
        check("reset_irq_any", timer_irq_any, 0);
        check("reset_readdata", readdata, 0);
    endtask

    typedef struct {
        logic        w;
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tab[35];

    function automatic vec_t mk(input logic w, input logic [5:0] a, input logic [31:0] d,
                                input logic [31:0] exp);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.exp = exp;
        return v;
    endfunction

    initial begin
        logic [31:0] v, v2;
        int k, sel, ch;
        logic [5:0] ra;
        logic [31:0] wd;
        bit found;

        // Reset defaults, then width rule / reserved / out-of-range behaviour.
        for (int i = 0; i < 18; i++) tab[i] = mk(1'b0, 6'(i), '0, 32'h0);
        tab[8]  = mk(1'b0, 6'd8,  '0, 32'hFFFF_FFFF);
        tab[9]  = mk(1'b0, 6'd9,  '0, 32'h0000_00FF);
        tab[12] = mk(1'b0, 6'd12, '0, 32'hFFFF_FFFF);
        tab[13] = mk(1'b0, 6'd13, '0, 32'h0000_00FF);
        tab[18] = mk(1'b0, 6'd63, '0, 32'h0);
        tab[19] = mk(1'b1, 6'd9,  32'hFFFF_FFFF, '0);
        tab[20] = mk(1'b0, 6'd9,  '0, 32'h0000_00FF);
        tab[21] = mk(1'b1, 6'd1,  32'hFFFF_FFFF, '0);
        tab[22] = mk(1'b0, 6'd1,  '0, 32'h0000_FFFF);
        tab[23] = mk(1'b1, 6'd6,  32'h1234_5678, '0);
        tab[24] = mk(1'b0, 6'd6,  '0, 32'h0);
        tab[25] = mk(1'b1, 6'd20, 32'hDEAD_BEEF, '0);
        tab[26] = mk(1'b0, 6'd20, '0, 32'h0);
        tab[27] = mk(1'b1, 6'd5,  32'h0000_00FF, '0);
        tab[28] = mk(1'b0, 6'd5,  '0, 32'h3);
        tab[29] = mk(1'b1, 6'd15, 32'hFFFF_FFFE, '0);
        tab[30] = mk(1'b0, 6'd15, '0, 32'h0);
        tab[31] = mk(1'b1, 6'd14, 32'hABCD_0123, '0);
        tab[32] = mk(1'b0, 6'd14, '0, 32'hABCD_0123);
        tab[33] = mk(1'b1, 6'd0,  32'hFFFF_FFFF, '0);
        tab[34] = mk(1'b0, 6'd0,  '0, 32'h1);

        model_reset();
        @(negedge clk);
        do_reset();
        idle(100);
        rd(6'd2, v);
        check("count_idle_100", v, 0);

        for (int i = 0; i < 35; i++) begin
            if (tab[i].w) wr(tab[i].a, tab[i].d);
            else begin
                rd(tab[i].a, v);
                check($sformatf("table%0d_a%0d", i, tab[i].a), v, tab[i].exp);
            end
        end

        // Prescaler.
        do_reset();
        wr(6'd1, 32'd3);
        wr(6'd0, 32'd1);
        idle(40);
        rd(6'd2, v);
        check("presc3_count_in_range", (v >= 9 && v <= 11), 1);
        wr(6'd1, 32'd0);
        rd(6'd2, v);
        idle(10);
        rd(6'd2, v2);
        check("presc0_rate", v2 - v, 11);

        // Reset in the middle of operation.
        do_reset();
        rd(6'd2, v);
        check("midreset_count", v, 0);
        rd(6'd0, v);
        check("midreset_ctrl", v, 0);

        // One-shot event on channel 0.
        wr(6'd9, 32'd0);
        wr(6'd8, 32'd20);
        wr(6'd5, 32'd1);
        wr(6'd0, 32'd1);
        wait_irq(0, 100);
        rd(6'd2, v);
        check("oneshot_event_count", v, 20);
        wr(6'd4, 32'd1);
        check("oneshot_irq_cleared", timer_irq[0], 0);
        idle(60);
        check("oneshot_no_recur", timer_irq[0], 0);
        rd(6'd8, v);
        check("oneshot_cmp_kept", v, 20);
        wr(6'd0, 32'd0);

        // Periodic mode on channel 1.
        wr(6'd2, 32'd0);
        wr(6'd3, 32'd0);
        wr(6'd13, 32'd0);
        wr(6'd12, 32'd10);
        wr(6'd14, 32'd5);
        wr(6'd15, 32'd1);
        wr(6'd4, 32'd3);
        wr(6'd5, 32'd2);
        wr(6'd0, 32'd1);
        for (int e = 0; e < 3; e++) begin
            wait_irq(1, 50);
            rd(6'd2, v);
            check($sformatf("periodic_event%0d", e), v, 10 + 5 * e);
            wr(6'd4, 32'd2);
        end
        rd(6'd12, v);
        check("periodic_cmp_after3", v, 25);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_en && m_pcnt == m_presc && ((m_cnt + 1) & MASK) == m_cmp[1]) begin
                found = 1;
                break;
            end
            idle(1);
        end
        check("coincide_found", found, 1);
        wr(6'd4, 32'd2);
        check("w1c_vs_set_irq", timer_irq[1], 1);
        rd(6'd4, v);
        check("w1c_vs_set_pend", v[1], 1);
        rd(6'd12, v);
        check("periodic_cmp_after4", v, 30);

        // Wrap at 40 bits and upper-bit masking.
        wr(6'd0, 32'd0);
        wr(6'd4, 32'd3);
        wr(6'd3, 32'hFFFF_FFFF);
        wr(6'd2, 32'hFFFF_FFFE);
        rd(6'd2, v);
        check("wrap_lo_before", v, 32'hFFFF_FFFE);
        rd(6'd3, v);
        check("wrap_hi_before", v, 32'h0000_00FF);
        wr(6'd9, 32'd0);
        wr(6'd8, 32'd1);
        wr(6'd5, 32'd1);
        wr(6'd0, 32'd1);
        wait_irq(0, 20);
        rd(6'd2, v);
        check("wrap_event_lo", v, 1);
        rd(6'd3, v);
        check("wrap_event_hi", v, 0);

        // Coherent 64-bit read and bus-write priority over a tick.
        wr(6'd0, 32'd0);
        wr(6'd3, 32'd1);
        wr(6'd2, 32'hFFFF_FFFF);
        wr(6'd1, 32'd0);
        wr(6'd0, 32'd1);
        rd(6'd2, v);
        check("coherent_lo", v, 32'hFFFF_FFFF);
        rd(6'd3, v);
        check("coherent_hi", v, 1);
        wr(6'd2, 32'd7);
        rd(6'd2, v);
        check("cnt_write_wins", v, 7);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 99);
            if (k < 30) idle(1);
            else if (k < 55) begin
                ra = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 23));
                cycle(1'b1, 1'b0, ra, '0);
            end else begin
                sel = $urandom_range(0, 9);
                ch  = $urandom_range(0, NUM_CH - 1);
                case (sel)
                    0: begin ra = 6'd0; wd = 32'($urandom_range(0, 9) != 0); end
                    1: begin ra = 6'd1; wd = $urandom_range(0, 3); end
                    2: begin ra = 6'd2; wd = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 50); end
                    3: begin ra = 6'd3; wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 2); end
                    4: begin ra = 6'd4; wd = $urandom_range(0, 3); end
                    5: begin ra = 6'd5; wd = $urandom_range(0, 3); end
                    6: begin ra = 6'(8 + 4 * ch); wd = 32'(m_cnt & LO32) + $urandom_range(1, 40); end
                    7: begin ra = 6'(9 + 4 * ch); wd = 32'(m_cnt >> 32); end
                    8: begin ra = 6'(10 + 4 * ch); wd = $urandom_range(0, 12); end
                    default: begin ra = 6'(11 + 4 * ch); wd = $urandom_range(0, 1); end
                endcase
                cycle(($urandom_range(0, 9) == 0), 1'b1, ra, wd);
            end
        end

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
